// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_flags.
// master drives requests and data; slave is the FIFO side.
interface sync_fifo_flags_if #(
  parameter int WORDSIZE = 8,
  parameter int ADDRSIZE = 3
);
  logic [WORDSIZE-1:0] write_data;
  logic                signal_write;
  logic                signal_read;
  logic                clear_err;
  logic [WORDSIZE-1:0] read_data;
  logic                read_valid;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output write_data, signal_write, signal_read, clear_err,
    input  read_data, read_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  write_data, signal_write, signal_read, clear_err,
    output read_data, read_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow and selectable registered or FWFT read.
module sync_fifo_flags #(
  parameter int WORDSIZE = 8,
  parameter int ADDRSIZE = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_flags_if.slave  fifo
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] CNT_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AF_C     = (ADDRSIZE+1)'(AF_LEVEL);
  localparam logic [ADDRSIZE:0] AE_C     = (ADDRSIZE+1)'(AE_LEVEL);

  logic [WORDSIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE:0] wptr_reg, rptr_reg;
  logic [ADDRSIZE:0] count_reg, count_next;
  logic              full_reg, empty_reg, almost_full_reg, almost_empty_reg;
  logic              overflow_reg, underflow_reg;
  logic              wr_ok, rd_ok;

  // Acceptance is judged on pre-edge flags only; no read/write bypass.
  assign wr_ok = fifo.signal_write & ~full_reg;
  assign rd_ok = fifo.signal_read  & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (wr_ok && !rd_ok)
      count_next = count_reg + CNT_ONE;
    else if (rd_ok && !wr_ok)
      count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      if (wr_ok) wptr_reg <= wptr_reg + CNT_ONE;
      if (rd_ok) rptr_reg <= rptr_reg + CNT_ONE;
      count_reg        <= count_next;
      full_reg         <= (count_next == DEPTH_C);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_C);
      almost_empty_reg <= (count_next <= AE_C);
      // A new error in the same cycle as clear_err keeps the flag set.
      overflow_reg  <= (fifo.signal_write & full_reg) | (overflow_reg & ~fifo.clear_err);
      underflow_reg <= (fifo.signal_read & empty_reg) | (underflow_reg & ~fifo.clear_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst)
      mem[wptr_reg[ADDRSIZE-1:0]] <= fifo.write_data;
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic [WORDSIZE-1:0] read_data_reg;
      logic                read_valid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          read_data_reg  <= '0;
          read_valid_reg <= 1'b0;
        end else begin
          read_valid_reg <= rd_ok;
          if (rd_ok)
            read_data_reg <= mem[rptr_reg[ADDRSIZE-1:0]];
        end
      end

      assign fifo.read_data  = read_data_reg;
      assign fifo.read_valid = read_valid_reg;
    end else begin : g_fwft
      // Head word is shown straight from the array while not empty.
      assign fifo.read_data  = empty_reg ? '0 : mem[rptr_reg[ADDRSIZE-1:0]];
      assign fifo.read_valid = ~empty_reg;
    end
  endgenerate

  assign fifo.count        = count_reg;
  assign fifo.full         = full_reg;
  assign fifo.empty        = empty_reg;
  assign fifo.almost_full  = almost_full_reg;
  assign fifo.almost_empty = almost_empty_reg;
  assign fifo.overflow     = overflow_reg;
  assign fifo.underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: table-driven flag/count vectors with a data
// scoreboard on a registered-read instance, plus an FWFT instance sequence.
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.WORDSIZE(8), .ADDRSIZE(3)) bus0 ();
  sync_fifo_flags_if #(.WORDSIZE(8), .ADDRSIZE(3)) bus1 ();

  sync_fifo_flags #(.WORDSIZE(8), .ADDRSIZE(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .fifo(bus0));
  sync_fifo_flags #(.WORDSIZE(8), .ADDRSIZE(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .fifo(bus1));

  typedef struct {
    bit         wr;
    bit         rd;
    bit         clr;
    logic [7:0] wd;
    int         cnt;
    bit         full;
    bit         empty;
    bit         af;
    bit         ae;
    bit         ovf;
    bit         udf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] model_q[$];
  logic [7:0] sb_q[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the registered-read FIFO; the model decides acceptance
  // from pre-edge occupancy and queues the word each accepted read must return.
  task automatic apply0(input bit wr, input bit rd, input bit clr, input logic [7:0] wd);
    bit acc_w, acc_r;
    logic [7:0] exp_d;
    acc_w = wr && (model_q.size() < 8);
    acc_r = rd && (model_q.size() > 0);
    if (acc_r) sb_q.push_back(model_q.pop_front());
    if (acc_w) model_q.push_back(wd);
    bus0.write_data   = wd;
    bus0.signal_write = wr;
    bus0.signal_read  = rd;
    bus0.clear_err    = clr;
    tick();
    chk("read_valid", {31'd0, bus0.read_valid}, {31'd0, acc_r});
    if (bus0.read_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_data: actual=%0h required=none", bus0.read_data);
      end else begin
        exp_d = sb_q.pop_front();
        chk("read_data", {24'd0, bus0.read_data}, {24'd0, exp_d});
      end
    end
    $display("txn0 wr=%0b rd=%0b clr=%0b wd=%02h -> count=%0d rv=%0b rdata=%02h",
             wr, rd, clr, wd, bus0.count, bus0.read_valid, bus0.read_data);
  endtask

  task automatic drive1(input bit wr, input bit rd, input logic [7:0] wd);
    bus1.write_data   = wd;
    bus1.signal_write = wr;
    bus1.signal_read  = rd;
    bus1.clear_err    = 1'b0;
    tick();
    $display("txn1 wr=%0b rd=%0b wd=%02h -> count=%0d rv=%0b rdata=%02h",
             wr, rd, wd, bus1.count, bus1.read_valid, bus1.read_data);
  endtask

  initial begin
    // wr rd clr wd | cnt full empty af ae ovf udf
    for (int i = 0; i < 5; i++) vecs.push_back('{0,0,0,8'h00, 0,0,1,0,1,0,0});
    vecs.push_back('{1,0,0,8'h11, 1,0,0,0,1,0,0});
    vecs.push_back('{1,0,0,8'h12, 2,0,0,0,1,0,0});
    vecs.push_back('{1,0,0,8'h13, 3,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h14, 4,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h15, 5,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h16, 6,0,0,1,0,0,0});
    vecs.push_back('{1,0,0,8'h17, 7,0,0,1,0,0,0});
    vecs.push_back('{1,0,0,8'h18, 8,1,0,1,0,0,0});
    vecs.push_back('{1,1,0,8'h99, 7,0,0,1,0,1,0});   // full: read wins, write rejected
    vecs.push_back('{0,0,1,8'h00, 7,0,0,1,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 6,0,0,1,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 5,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 4,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 3,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 2,0,0,0,1,0,0});
    vecs.push_back('{0,1,0,8'h00, 1,0,0,0,1,0,0});
    vecs.push_back('{0,1,0,8'h00, 0,0,1,0,1,0,0});
    vecs.push_back('{0,1,0,8'h00, 0,0,1,0,1,0,1});   // underflow on empty
    vecs.push_back('{0,1,1,8'h00, 0,0,1,0,1,0,1});   // set beats clear
    vecs.push_back('{0,0,1,8'h00, 0,0,1,0,1,0,0});
    vecs.push_back('{0,1,0,8'h00, 0,0,1,0,1,0,1});
    vecs.push_back('{1,1,0,8'hA5, 1,0,0,0,1,0,1});   // empty: read rejected
    vecs.push_back('{0,1,0,8'h00, 0,0,1,0,1,0,1});
    vecs.push_back('{0,0,1,8'h00, 0,0,1,0,1,0,0});

    rst = 1'b1;
    bus0.write_data = '0; bus0.signal_write = 1'b0; bus0.signal_read = 1'b0; bus0.clear_err = 1'b0;
    bus1.write_data = '0; bus1.signal_write = 1'b0; bus1.signal_read = 1'b0; bus1.clear_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset read_data", {24'd0, bus0.read_data}, 32'h0);

    foreach (vecs[r]) begin
      apply0(vecs[r].wr, vecs[r].rd, vecs[r].clr, vecs[r].wd);
      chk($sformatf("count[r%0d]", r),    {28'd0, bus0.count},        vecs[r].cnt);
      chk($sformatf("full[r%0d]", r),     {31'd0, bus0.full},         {31'd0, vecs[r].full});
      chk($sformatf("empty[r%0d]", r),    {31'd0, bus0.empty},        {31'd0, vecs[r].empty});
      chk($sformatf("alm_full[r%0d]", r), {31'd0, bus0.almost_full},  {31'd0, vecs[r].af});
      chk($sformatf("alm_empty[r%0d]", r),{31'd0, bus0.almost_empty}, {31'd0, vecs[r].ae});
      chk($sformatf("overflow[r%0d]", r), {31'd0, bus0.overflow},     {31'd0, vecs[r].ovf});
      chk($sformatf("underflow[r%0d]", r),{31'd0, bus0.underflow},    {31'd0, vecs[r].udf});
    end

    // Alternating write/read walks both pointers across the wrap point.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) apply0(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      else            apply0(1'b0, 1'b1, 1'b0, 8'h00);
      chk("wrap count", {28'd0, bus0.count}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("wrap full",  {31'd0, bus0.full},  32'd0);
    end
    chk("scoreboard drained", sb_q.size(), 32'd0);

    // FWFT instance: word falls through without a read request.
    drive1(1'b1, 1'b0, 8'h3C);
    drive1(1'b0, 1'b0, 8'h00);
    chk("fwft read_valid", {31'd0, bus1.read_valid}, 32'd1);
    chk("fwft read_data",  {24'd0, bus1.read_data},  32'h3C);
    chk("fwft count",      {28'd0, bus1.count},      32'd1);
    drive1(1'b0, 1'b1, 8'h00);
    chk("fwft pop empty",  {31'd0, bus1.empty},      32'd1);
    chk("fwft pop rv",     {31'd0, bus1.read_valid}, 32'd0);
    for (int i = 0; i < 4; i++) drive1(1'b1, 1'b0, 8'(8'h50 + i));
    chk("fwft head",       {24'd0, bus1.read_data},  32'h50);
    chk("fwft count4",     {28'd0, bus1.count},      32'd4);
    drive1(1'b0, 1'b1, 8'h00);
    chk("fwft next head",  {24'd0, bus1.read_data},  32'h51);
    drive1(1'b1, 1'b0, 8'h54);
    chk("fwft count pre-rst", {28'd0, bus1.count},   32'd4);

    // Reset mid-stream overrides a simultaneous write.
    rst = 1'b1;
    bus1.signal_write = 1'b1;
    bus1.write_data   = 8'h77;
    tick();
    rst = 1'b0;
    bus1.signal_write = 1'b0;
    $display("txn1 rst=1 wr=1 -> count=%0d empty=%0b", bus1.count, bus1.empty);
    chk("fwft rst count", {28'd0, bus1.count},      32'd0);
    chk("fwft rst empty", {31'd0, bus1.empty},      32'd1);
    chk("fwft rst rv",    {31'd0, bus1.read_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
